one_counter_fsmd: RTL

- Parametrised, self-sequenced ones/zeros counter datapath: operand register, shift unit, count accumulator, result register and a control FSM.
- Replaces externally sequenced ones counting (caller driving register addresses and ALU selects every cycle) with a single Start/Done handshake.
- Sits beside the lab register-file datapaths. Result is usable directly or written back through DataIn-style buses.
- New versus the previous generation: width parameter, zeros-count mode, early termination and a busy/done handshake.

---
 rtl/one_counter_fsmd.sv | 83 ++++++++
 1 files changed

// File: rtl/one_counter_fsmd.sv
// Self-sequenced ones/zeros counter: loads an operand on Start, shifts it right
// while accumulating set bits, and stops as soon as no set bits remain above bit 0.
module one_counter_fsmd #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic             Mode,
  input  logic [WIDTH-1:0] DataIn,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Out,
  output logic [WIDTH-1:0] Datapath
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   r_q, r_d;
  logic [CNT_W-1:0]   c_q, c_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic [CNT_W-1:0]   sum;

  assign sum = c_q + CNT_W'(r_q[0]);

  // Zeros mode simply counts ones of the inverted operand, so one datapath serves both.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    c_d     = c_q;
    out_d   = out_q;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          r_d     = Mode ? ~DataIn : DataIn;
          c_d     = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        c_d = sum;
        r_d = r_q >> 1;
        // Nothing left above bit 0: this edge's sum is final.
        if (r_q[WIDTH-1:1] == '0) begin
          out_d   = WIDTH'(sum);
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      r_q     <= '0;
      c_q     <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      c_q     <= c_d;
      out_q   <= out_d;
    end
  end

  assign Busy     = (state_q == SHIFT);
  assign Done     = (state_q == DONE);
  assign Out      = out_q;
  assign Datapath = r_q;

endmodule
